butterfly_cfg: RTL and testbench

Parametrised radix-2 DIT butterfly, the next-generation core for the FFT stages in the FRB channeliser datapath. It computes yp = xp + W·xq and yq = xp − W·xq.
- Fixed-latency, fully pipelined datapath with an inline multiplier pipeline of configurable depth.
- Forward/inverse (conjugate-twiddle) selectable per sample.
- Optional per-sample divide-by-2 stage scaling.
- Round-half-up, saturation, and per-sample plus sticky overflow reporting.
- Accepts one sample pair per clock, with no stalls.

---
 rtl/butterfly_cfg.sv | 218 +++++++++++++++++++++
 tb/tb_butterfly_cfg.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_cfg.sv
// butterfly_cfg: fully pipelined radix-2 DIT butterfly.
//   yp = xp + W*xq, yq = xp - W*xq, with W or conj(W) selected per sample.
// Latency is MULT_STAGES + 4 cycles, one sample pair accepted per clock, no stalls.
//
// Ports:
//   clk_data                      datapath clock
//   rst                           synchronous active-high reset
//   in_valid                      input sample pair valid
//   inverse                       1 = multiply by conj(W)
//   scale                         1 = extra divide-by-2 on the outputs
//   xp_real/xp_imag               upper input (signed DATA_WIDTH)
//   xq_real/xq_imag               lower input (signed DATA_WIDTH)
//   factor_real/factor_imag       twiddle (signed TW_WIDTH, TW_FRAC fractional bits)
//   ovf_clr                       clears ovf_sticky
//   out_valid                     output valid
//   yp_*/yq_*                     rounded, saturated results
//   ovf                           saturation on the current output sample
//   ovf_sticky                    latched OR of ovf since reset/clear
module butterfly_cfg #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned TW_WIDTH    = 16,
    parameter int unsigned TW_FRAC     = 13,
    parameter int unsigned MULT_STAGES = 3
) (
    input  logic                         clk_data,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         inverse,
    input  logic                         scale,
    input  logic signed [DATA_WIDTH-1:0] xp_real,
    input  logic signed [DATA_WIDTH-1:0] xp_imag,
    input  logic signed [DATA_WIDTH-1:0] xq_real,
    input  logic signed [DATA_WIDTH-1:0] xq_imag,
    input  logic signed [TW_WIDTH-1:0]   factor_real,
    input  logic signed [TW_WIDTH-1:0]   factor_imag,
    input  logic                         ovf_clr,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] yp_real,
    output logic signed [DATA_WIDTH-1:0] yp_imag,
    output logic signed [DATA_WIDTH-1:0] yq_real,
    output logic signed [DATA_WIDTH-1:0] yq_imag,
    output logic                         ovf,
    output logic                         ovf_sticky
);

    localparam int unsigned PW   = DATA_WIDTH + TW_WIDTH;
    localparam int unsigned SW   = PW + 2;
    localparam int unsigned L    = MULT_STAGES + 4;
    localparam int unsigned LAST = MULT_STAGES - 1;

    localparam logic signed [SW-1:0] SAT_MAX =
        {{(SW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN =
        {{(SW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
    // Half-LSB rounding offsets for the two possible output shifts.
    localparam logic signed [SW-1:0] BIAS0 = SW'(1) <<< (TW_FRAC - 1);
    localparam logic signed [SW-1:0] BIAS1 = SW'(1) <<< TW_FRAC;

    // Valid shift register; data stages run free and are never reset.
    logic [L-1:0] vld_q;

    always_ff @(posedge clk_data) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[L-2:0], in_valid};
        end
    end

    assign out_valid = vld_q[L-1];

    // S1: input register
    logic signed [DATA_WIDTH-1:0] s1_xp_re_q, s1_xp_im_q, s1_xq_re_q, s1_xq_im_q;
    logic signed [TW_WIDTH-1:0]   s1_w_re_q, s1_w_im_q;
    logic                         s1_inv_q, s1_scl_q;

    always_ff @(posedge clk_data) begin
        s1_xp_re_q <= xp_real;
        s1_xp_im_q <= xp_imag;
        s1_xq_re_q <= xq_real;
        s1_xq_im_q <= xq_imag;
        s1_w_re_q  <= factor_real;
        s1_w_im_q  <= factor_imag;
        s1_inv_q   <= inverse;
        s1_scl_q   <= scale;
    end

    // Multiplier pipeline: products at full width, so (-2^(TW-1))^2 cases fit.
    logic signed [PW-1:0] ar_ext, ai_ext, wr_ext, wi_ext;
    assign ar_ext = PW'(s1_xq_re_q);
    assign ai_ext = PW'(s1_xq_im_q);
    assign wr_ext = PW'(s1_w_re_q);
    assign wi_ext = PW'(s1_w_im_q);

    logic signed [PW-1:0]         p_rr_q [MULT_STAGES];
    logic signed [PW-1:0]         p_ii_q [MULT_STAGES];
    logic signed [PW-1:0]         p_ri_q [MULT_STAGES];
    logic signed [PW-1:0]         p_ir_q [MULT_STAGES];
    logic signed [DATA_WIDTH-1:0] m_xp_re_q [MULT_STAGES];
    logic signed [DATA_WIDTH-1:0] m_xp_im_q [MULT_STAGES];
    logic [MULT_STAGES-1:0]       m_inv_q, m_scl_q;

    always_ff @(posedge clk_data) begin
        p_rr_q[0]    <= ar_ext * wr_ext;
        p_ii_q[0]    <= ai_ext * wi_ext;
        p_ri_q[0]    <= ar_ext * wi_ext;
        p_ir_q[0]    <= ai_ext * wr_ext;
        m_xp_re_q[0] <= s1_xp_re_q;
        m_xp_im_q[0] <= s1_xp_im_q;
        m_inv_q[0]   <= s1_inv_q;
        m_scl_q[0]   <= s1_scl_q;
        for (int i = 1; i < int'(MULT_STAGES); i++) begin
            p_rr_q[i]    <= p_rr_q[i-1];
            p_ii_q[i]    <= p_ii_q[i-1];
            p_ri_q[i]    <= p_ri_q[i-1];
            p_ir_q[i]    <= p_ir_q[i-1];
            m_xp_re_q[i] <= m_xp_re_q[i-1];
            m_xp_im_q[i] <= m_xp_im_q[i-1];
            m_inv_q[i]   <= m_inv_q[i-1];
            m_scl_q[i]   <= m_scl_q[i-1];
        end
    end

    // Complex combine; inverse uses conj(W), flipping the sign of every wi term.
    logic signed [SW-1:0] rr, ii, ri, ir, c_re_d, c_im_d;
    assign rr = SW'(p_rr_q[LAST]);
    assign ii = SW'(p_ii_q[LAST]);
    assign ri = SW'(p_ri_q[LAST]);
    assign ir = SW'(p_ir_q[LAST]);

    always_comb begin
        c_re_d = rr - ii;
        c_im_d = ri + ir;
        if (m_inv_q[LAST]) begin
            c_re_d = rr + ii;
            c_im_d = ir - ri;
        end
    end

    logic signed [SW-1:0]         c_re_q, c_im_q;
    logic signed [DATA_WIDTH-1:0] c_xp_re_q, c_xp_im_q;
    logic                         c_scl_q;

    always_ff @(posedge clk_data) begin
        c_re_q    <= c_re_d;
        c_im_q    <= c_im_d;
        c_xp_re_q <= m_xp_re_q[LAST];
        c_xp_im_q <= m_xp_im_q[LAST];
        c_scl_q   <= m_scl_q[LAST];
    end

    // Add/sub: xp brought to the product's binary point.
    logic signed [SW-1:0] xp_sh_re, xp_sh_im;
    assign xp_sh_re = SW'(c_xp_re_q) <<< TW_FRAC;
    assign xp_sh_im = SW'(c_xp_im_q) <<< TW_FRAC;

    logic signed [SW-1:0] a_p_re_q, a_p_im_q, a_q_re_q, a_q_im_q;
    logic                 a_scl_q;

    always_ff @(posedge clk_data) begin
        a_p_re_q <= xp_sh_re + c_re_q;
        a_p_im_q <= xp_sh_im + c_im_q;
        a_q_re_q <= xp_sh_re - c_re_q;
        a_q_im_q <= xp_sh_im - c_im_q;
        a_scl_q  <= c_scl_q;
    end

    // Round half toward +inf, then clamp. MSB of the result is the clamp flag.
    function automatic logic [DATA_WIDTH:0] rnd_sat(input logic signed [SW-1:0] v,
                                                    input logic scl);
        logic signed [SW-1:0] r;
        r = scl ? ((v + BIAS1) >>> (TW_FRAC + 1)) : ((v + BIAS0) >>> TW_FRAC);
        if (r > SAT_MAX) begin
            rnd_sat = {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
        end else if (r < SAT_MIN) begin
            rnd_sat = {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
        end else begin
            rnd_sat = {1'b0, r[DATA_WIDTH-1:0]};
        end
    endfunction

    logic [DATA_WIDTH:0] rs_p_re, rs_p_im, rs_q_re, rs_q_im;
    logic                sat_any;

    always_comb begin
        rs_p_re = rnd_sat(a_p_re_q, a_scl_q);
        rs_p_im = rnd_sat(a_p_im_q, a_scl_q);
        rs_q_re = rnd_sat(a_q_re_q, a_scl_q);
        rs_q_im = rnd_sat(a_q_im_q, a_scl_q);
        sat_any = rs_p_re[DATA_WIDTH] | rs_p_im[DATA_WIDTH] |
                  rs_q_re[DATA_WIDTH] | rs_q_im[DATA_WIDTH];
    end

    // Output register: data holds across bubbles, ovf only reported with valid.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            yp_real    <= '0;
            yp_imag    <= '0;
            yq_real    <= '0;
            yq_imag    <= '0;
            ovf        <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            if (vld_q[L-2]) begin
                yp_real <= rs_p_re[DATA_WIDTH-1:0];
                yp_imag <= rs_p_im[DATA_WIDTH-1:0];
                yq_real <= rs_q_re[DATA_WIDTH-1:0];
                yq_imag <= rs_q_im[DATA_WIDTH-1:0];
                ovf     <= sat_any;
            end else begin
                ovf     <= 1'b0;
            end
            // Set has priority over clear.
            ovf_sticky <= (vld_q[L-2] & sat_any) | (ovf_sticky & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_butterfly_cfg.sv
module tb_butterfly_cfg;

    localparam int LAT = 7;
    localparam int TF  = 13;

    logic               clk_data = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               inverse = 1'b0;
    logic               scale = 1'b0;
    logic               ovf_clr = 1'b0;
    logic signed [15:0] xp_real = '0, xp_imag = '0, xq_real = '0, xq_imag = '0;
    logic signed [15:0] factor_real = '0, factor_imag = '0;
    logic               out_valid, ovf, ovf_sticky;
    logic signed [15:0] yp_real, yp_imag, yq_real, yq_imag;

    butterfly_cfg dut (
        .clk_data    (clk_data),
        .rst         (rst),
        .in_valid    (in_valid),
        .inverse     (inverse),
        .scale       (scale),
        .xp_real     (xp_real),
        .xp_imag     (xp_imag),
        .xq_real     (xq_real),
        .xq_imag     (xq_imag),
        .factor_real (factor_real),
        .factor_imag (factor_imag),
        .ovf_clr     (ovf_clr),
        .out_valid   (out_valid),
        .yp_real     (yp_real),
        .yp_imag     (yp_imag),
        .yq_real     (yq_real),
        .yq_imag     (yq_imag),
        .ovf         (ovf),
        .ovf_sticky  (ovf_sticky)
    );

    always #5 clk_data = ~clk_data;

    int cyc = 0;
    always @(posedge clk_data) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int ypr, ypi, yqr, yqi;
        bit ovf;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail = 0;
    bit   mon_en = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic exp_t mk(input int a, input int b, input int c, input int d,
                                input bit o);
        exp_t e;
        e.cyc = 0;
        e.ypr = a;
        e.ypi = b;
        e.yqr = c;
        e.yqi = d;
        e.ovf = o;
        return e;
    endfunction

    // Reference: exact complex arithmetic, round half up, clamp to 16 bits.
    function automatic longint rnd(input longint v, input bit scl, inout bit o);
        int     sh;
        longint r;
        sh = TF + int'(scl);
        r  = (v + (longint'(1) << (sh - 1))) >>> sh;
        if (r > 32767) begin
            o = 1;
            r = 32767;
        end else if (r < -32768) begin
            o = 1;
            r = -32768;
        end
        return r;
    endfunction

    function automatic exp_t model(input int xpr, input int xpi, input int xqr, input int xqi,
                                   input int wr, input int wi, input bit inv, input bit scl);
        longint wie, tr, ti, pr, pi;
        bit     o;
        exp_t   e;
        wie = inv ? -longint'(wi) : longint'(wi);
        tr  = longint'(xqr) * wr - longint'(xqi) * wie;
        ti  = longint'(xqr) * wie + longint'(xqi) * wr;
        pr  = longint'(xpr) * (longint'(1) << TF);
        pi  = longint'(xpi) * (longint'(1) << TF);
        o   = 0;
        e.cyc = 0;
        e.ypr = int'(rnd(pr + tr, scl, o));
        e.ypi = int'(rnd(pi + ti, scl, o));
        e.yqr = int'(rnd(pr - tr, scl, o));
        e.yqi = int'(rnd(pi - ti, scl, o));
        e.ovf = o;
        return e;
    endfunction

    task automatic drive(input int xpr, input int xpi, input int xqr, input int xqi,
                         input int wr, input int wi, input bit inv, input bit scl);
        xp_real     = 16'(xpr);
        xp_imag     = 16'(xpi);
        xq_real     = 16'(xqr);
        xq_imag     = 16'(xqi);
        factor_real = 16'(wr);
        factor_imag = 16'(wi);
        inverse     = inv;
        scale       = scl;
    endtask

    task automatic send(input int xpr, input int xpi, input int xqr, input int xqi,
                        input int wr, input int wi, input bit inv, input bit scl,
                        input exp_t e);
        exp_t ee;
        drive(xpr, xpi, xqr, xqi, wr, wi, inv, scl);
        in_valid = 1'b1;
        ee = e;
        ee.cyc = cyc + LAT;
        sb.push_back(ee);
        @(posedge clk_data);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input int xpr, input int xpi, input int xqr, input int xqi,
                             input int wr, input int wi, input bit inv, input bit scl);
        send(xpr, xpi, xqr, xqi, wr, wi, inv, scl, model(xpr, xpi, xqr, xqi, wr, wi, inv, scl));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk_data);
            #1;
        end
    endtask

    function automatic int rs(input int lim);
        return int'($urandom_range(0, 2 * lim)) - lim;
    endfunction

    function automatic int rtw();
        int k;
        k = int'($urandom_range(0, 7));
        if (k == 0) return -32768;
        if (k == 1) return rs(32767);
        return rs(8192);
    endfunction

    function automatic int rdat();
        if ($urandom_range(0, 1) == 0) return rs(32767);
        return rs(300);
    endfunction

    // Monitor: pops the scoreboard when an output is due and checks every cycle.
    exp_t held;
    bit   st_exp = 0;
    bit   prev_rst = 1;
    bit   prev_clr = 0;

    always @(negedge clk_data) begin
        if (mon_en) begin
            bit   exp_v;
            bit   ovf_exp;
            exp_t e;
            if (prev_rst) begin
                held   = mk(0, 0, 0, 0, 0);
                st_exp = 0;
            end else begin
                st_exp = st_exp & ~prev_clr;
            end
            exp_v   = (sb.size() > 0) && (sb[0].cyc == cyc);
            ovf_exp = 0;
            chk("out_valid", longint'(out_valid), longint'(exp_v));
            if (exp_v) begin
                e       = sb.pop_front();
                held    = e;
                ovf_exp = e.ovf;
                if (e.ovf) st_exp = 1;
            end
            chk("yp_real", longint'(yp_real), held.ypr);
            chk("yp_imag", longint'(yp_imag), held.ypi);
            chk("yq_real", longint'(yq_real), held.yqr);
            chk("yq_imag", longint'(yq_imag), held.yqi);
            chk("ovf", longint'(ovf), longint'(ovf_exp));
            chk("ovf_sticky", longint'(ovf_sticky), longint'(st_exp));
            prev_rst = rst;
            prev_clr = ovf_clr;
        end
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        exp_t keep[$];
        int   sent;
        @(posedge clk_data);
        #1;
        mon_en = 1;
        idle(2);
        rst = 1'b0;
        idle(2);

        // Unity twiddle, forward
        send(1000, 0, 500, 0, 8192, 0, 0, 0, mk(1500, 0, 500, 0, 0));
        idle(8);

        // Complex twiddle, forward then inverse back-to-back
        send(0, 0, 100, 200, 0, -8192, 0, 0, mk(200, -100, -200, 100, 0));
        send(0, 0, 100, 200, 0, -8192, 1, 0, mk(-200, 100, 200, -100, 0));
        idle(8);

        // Saturation, then scaled
        send(30000, -30000, 30000, -30000, 8192, 0, 0, 0, mk(32767, -32768, 0, 0, 1));
        send(30000, -30000, 30000, -30000, 8192, 0, 0, 1, mk(30000, -30000, 0, 0, 0));
        idle(8);

        // Clear coinciding with a new saturation: set wins
        send(30000, -30000, 30000, -30000, 8192, 0, 0, 0, mk(32767, -32768, 0, 0, 1));
        idle(5);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        @(negedge clk_data);
        chk("sticky_set_wins", longint'(ovf_sticky), 1);
        @(posedge clk_data);
        #1;
        idle(2);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        @(negedge clk_data);
        chk("sticky_cleared", longint'(ovf_sticky), 0);
        @(posedge clk_data);
        #1;

        // Rounding with scale
        send(3, -3, 0, 0, 8192, 0, 0, 1, mk(2, -1, 2, -1, 0));
        send(1, -1, 0, 0, 8192, 0, 0, 1, mk(1, 0, 1, 0, 0));
        idle(8);

        // Random streaming with gaps and occasional sticky clears
        sent = 0;
        while (sent < 64) begin
            ovf_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                send_rand(rdat(), rdat(), rdat(), rdat(), rtw(), rtw(),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                sent++;
            end
        end
        ovf_clr = 1'b0;
        idle(10);

        // Reset mid-stream on the 3rd of 5 samples
        send_rand(rs(1000), rs(1000), rs(1000), rs(1000), rtw(), rtw(), 0, 0);
        send_rand(rs(1000), rs(1000), rs(1000), rs(1000), rtw(), rtw(), 1, 1);
        drive(123, 456, 789, -321, 8192, 0, 0, 0);
        in_valid = 1'b1;
        rst      = 1'b1;
        keep.delete();
        foreach (sb[i]) if (sb[i].cyc <= cyc) keep.push_back(sb[i]);
        sb = keep;
        @(posedge clk_data);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        send_rand(rs(2000), rs(2000), rs(2000), rs(2000), rtw(), rtw(), 0, 1);
        send_rand(rs(2000), rs(2000), rs(2000), rs(2000), rtw(), rtw(), 1, 0);
        idle(12);

        chk("scoreboard_drained", longint'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
